// File: rtl/pipe_field_engine.sv
// Flappy Bird obstacle engine: pipe table scrolled by a per-frame walk during vertical blank,
// with LFSR-gap recycling, pass scoring, bird collision and the RUN/DEAD game state.
module pipe_field_engine #(
  parameter int PIPE_COUNT   = 5,
  parameter int PIPE_WIDTH   = 52,
  parameter int GAP_HEIGHT   = 90,
  parameter int PIPE_SPACING = 127,
  parameter int SCROLL_STEP  = 1,
  parameter int X_START      = 440,
  parameter int GAP_MIN      = 80,
  parameter int GAP_RANGE    = 270,
  parameter int GROUND_Y     = 440,
  parameter int BIRD_X       = 100,
  parameter int BIRD_W       = 34,
  parameter int BIRD_H       = 24
) (
  input  logic        clk50,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        start,
  input  logic [9:0]  bird_y,
  input  logic [9:0]  hpix,
  input  logic [9:0]  vpix,
  output logic        pipe_pixel,
  output logic        collision,
  output logic [15:0] score,
  output logic [1:0]  game_state,
  output logic        busy
);

  localparam int IDX_W = (PIPE_COUNT > 2) ? $clog2(PIPE_COUNT) : 1;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WAIT  = 3'd1;
  localparam logic [2:0] ST_SCAN  = 3'd2;
  localparam logic [2:0] ST_MOVE  = 3'd3;
  localparam logic [2:0] ST_CHECK = 3'd4;
  localparam logic [2:0] ST_DEAD  = 3'd5;

  localparam logic [7:0] LFSR_SEED = 8'h5A;

  function automatic logic [10:0] init_x(input int i);
    return 11'(X_START + i * PIPE_SPACING);
  endfunction

  function automatic logic [8:0] init_gap(input int i);
    return 9'(GAP_MIN + ((i * 40) % GAP_RANGE));
  endfunction

  logic [2:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q;
  logic [10:0]      max_x_q;
  logic             hit_q;
  logic [7:0]       lfsr_q;
  logic             collision_q;
  logic [15:0]      score_q;
  logic             pipe_pixel_q;
  logic [10:0]      x_q   [PIPE_COUNT];
  logic [8:0]       gap_q [PIPE_COUNT];

  logic        last_idx;
  logic        do_init;
  logic [10:0] cur_x, new_x;
  logic [8:0]  cur_gap, new_gap, gap_rand;
  logic [11:0] old_right, new_right;
  logic [10:0] bird_bot;
  logic        recycle, pass, outside_gap, pipe_hit, ground_hit;
  logic        pix_hit;

  assign last_idx = (idx_q == IDX_W'(PIPE_COUNT - 1));
  assign cur_x    = x_q[idx_q];
  assign cur_gap  = gap_q[idx_q];
  assign bird_bot = {1'b0, bird_y} + 11'(BIRD_H);
  assign gap_rand = 9'(GAP_MIN) + 9'(int'(lfsr_q) % GAP_RANGE);

  // Entry update for the MOVE walk; max_x_q holds the pre-move maximum from SCAN.
  assign recycle   = (cur_x <= 11'(SCROLL_STEP));
  assign new_x     = recycle ? 11'({1'b0, max_x_q} + 12'(PIPE_SPACING - SCROLL_STEP))
                             : cur_x - 11'(SCROLL_STEP);
  assign new_gap   = recycle ? gap_rand : cur_gap;
  assign old_right = {1'b0, cur_x} + 12'(PIPE_WIDTH);
  assign new_right = {1'b0, new_x} + 12'(PIPE_WIDTH);
  assign pass      = (old_right > 12'(BIRD_X)) && (new_right <= 12'(BIRD_X));

  assign outside_gap = ({1'b0, bird_y} < {2'b0, new_gap}) ||
                       (bird_bot > ({2'b0, new_gap} + 11'(GAP_HEIGHT)));
  assign pipe_hit    = ({1'b0, new_x} < 12'(BIRD_X + BIRD_W)) &&
                       (new_right > 12'(BIRD_X)) && outside_gap;
  assign ground_hit  = (bird_bot > 11'(GROUND_Y));

  always_comb begin
    state_d = state_q;
    do_init = 1'b0;
    case (state_q)
      ST_IDLE, ST_DEAD: begin
        if (start) begin
          do_init = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT:  if (frame_tick) state_d = ST_SCAN;
      ST_SCAN:  if (last_idx) state_d = ST_MOVE;
      ST_MOVE:  if (last_idx) state_d = ST_CHECK;
      ST_CHECK: state_d = (hit_q || ground_hit) ? ST_DEAD : ST_WAIT;
      default:  state_d = ST_IDLE;
    endcase
  end

  // The pixel test reads the live table; it only changes during blank.
  always_comb begin
    pix_hit = 1'b0;
    for (int i = 0; i < PIPE_COUNT; i++) begin
      if (({1'b0, hpix} >= x_q[i]) &&
          ({2'b0, hpix} < ({1'b0, x_q[i]} + 12'(PIPE_WIDTH))) &&
          (({1'b0, vpix} < {2'b0, gap_q[i]}) ||
           ({1'b0, vpix} >= ({2'b0, gap_q[i]} + 11'(GAP_HEIGHT)))) &&
          (vpix < 10'(GROUND_Y))) begin
        pix_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      max_x_q      <= '0;
      hit_q        <= 1'b0;
      lfsr_q       <= LFSR_SEED;
      collision_q  <= 1'b0;
      score_q      <= '0;
      pipe_pixel_q <= 1'b0;
      for (int i = 0; i < PIPE_COUNT; i++) begin
        x_q[i]   <= init_x(i);
        gap_q[i] <= init_gap(i);
      end
    end else begin
      state_q      <= state_d;
      pipe_pixel_q <= pix_hit;
      if (do_init) begin
        score_q     <= '0;
        collision_q <= 1'b0;
        for (int i = 0; i < PIPE_COUNT; i++) begin
          x_q[i]   <= init_x(i);
          gap_q[i] <= init_gap(i);
        end
      end
      case (state_q)
        ST_WAIT: begin
          idx_q   <= '0;
          max_x_q <= '0;
          hit_q   <= 1'b0;
        end
        ST_SCAN: begin
          if (cur_x > max_x_q) max_x_q <= cur_x;
          idx_q <= last_idx ? '0 : idx_q + 1'b1;
        end
        ST_MOVE: begin
          x_q[idx_q]   <= new_x;
          gap_q[idx_q] <= new_gap;
          if (recycle) lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5]};
          if (pass && (score_q != 16'hFFFF)) score_q <= score_q + 16'd1;
          if (pipe_hit) hit_q <= 1'b1;
          idx_q <= last_idx ? '0 : idx_q + 1'b1;
        end
        ST_CHECK: begin
          if (hit_q || ground_hit) collision_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign pipe_pixel = pipe_pixel_q;
  assign collision  = collision_q;
  assign score      = score_q;
  assign busy       = (state_q == ST_SCAN) || (state_q == ST_MOVE) || (state_q == ST_CHECK);

  always_comb begin
    case (state_q)
      ST_IDLE: game_state = 2'd0;
      ST_DEAD: game_state = 2'd2;
      default: game_state = 2'd1;
    endcase
  end

endmodule

// File: tb/tb_pipe_field_engine.sv
// Directed bench for pipe_field_engine; table contents are observed through pipe_pixel by
// probing pipe edges and gap rows.
module tb_pipe_field_engine;

  logic        clk50 = 1'b0;
  logic        reset;
  logic        frame_tick;
  logic        start;
  logic [9:0]  bird_y;
  logic [9:0]  hpix;
  logic [9:0]  vpix;
  logic        pipe_pixel;
  logic        collision;
  logic [15:0] score;
  logic [1:0]  game_state;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  pipe_field_engine dut (
    .clk50      (clk50),
    .reset      (reset),
    .frame_tick (frame_tick),
    .start      (start),
    .bird_y     (bird_y),
    .hpix       (hpix),
    .vpix       (vpix),
    .pipe_pixel (pipe_pixel),
    .collision  (collision),
    .score      (score),
    .game_state (game_state),
    .busy       (busy)
  );

  always #10 clk50 = ~clk50;

  // One accepted frame: pulse, then wait well past the 12-cycle walk.
  task automatic tick();
    @(negedge clk50) frame_tick = 1'b1;
    @(negedge clk50) frame_tick = 1'b0;
    repeat (12) @(negedge clk50);
  endtask

  task automatic pulse_start();
    @(negedge clk50) start = 1'b1;
    @(negedge clk50) start = 1'b0;
  endtask

  task automatic probe(input logic [9:0] h, input logic [9:0] v, output logic p);
    @(negedge clk50);
    hpix = h;
    vpix = v;
    @(negedge clk50);
    p = pipe_pixel;
  endtask

  task automatic test_reset();
    logic p;
    logic [9:0] hs [4] = '{10'd439, 10'd440, 10'd491, 10'd492};
    logic       ex [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    reset = 1'b0; frame_tick = 1'b0; start = 1'b0;
    bird_y = 10'd130; hpix = 10'd0; vpix = 10'd0;
    #5 reset = 1'b1;
    repeat (3) @(negedge clk50);
    n_tests++; if (game_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", game_state); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_tests++; if (score !== 16'd0) begin n_fail++; $display("FAIL reset_score: got %0d want 0", score); end
    n_tests++; if (collision !== 1'b0) begin n_fail++; $display("FAIL reset_collision: got %b want 0", collision); end
    n_tests++; if (pipe_pixel !== 1'b0) begin n_fail++; $display("FAIL reset_pixel: got %b want 0", pipe_pixel); end
    @(negedge clk50) reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      probe(hs[k], 10'd0, p);
      n_tests++; if (p !== ex[k]) begin n_fail++; $display("FAIL reset_table h=%0d: got %b want %b", hs[k], p, ex[k]); end
    end
    // Frame ticks are ignored in IDLE.
    @(negedge clk50) frame_tick = 1'b1;
    @(negedge clk50) frame_tick = 1'b0;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_tick_busy: got %b want 0", busy); end
    n_tests++; if (game_state !== 2'd0) begin n_fail++; $display("FAIL idle_tick_state: got %0d want 0", game_state); end
  endtask

  task automatic test_first_frame();
    logic p;
    int cnt;
    logic [9:0] hs [8] = '{10'd438, 10'd439, 10'd490, 10'd491, 10'd946, 10'd947, 10'd998, 10'd999};
    logic       ex [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    pulse_start();
    n_tests++; if (game_state !== 2'd1) begin n_fail++; $display("FAIL start_state: got %0d want 1", game_state); end
    @(negedge clk50) frame_tick = 1'b1;
    @(negedge clk50) frame_tick = 1'b0;
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (busy === 1'b1) cnt++;
      @(negedge clk50);
    end
    n_tests++; if (cnt != 11) begin n_fail++; $display("FAIL busy_cycles: got %0d want 11", cnt); end
    n_tests++; if (game_state !== 2'd1) begin n_fail++; $display("FAIL frame1_state: got %0d want 1", game_state); end
    n_tests++; if (score !== 16'd0) begin n_fail++; $display("FAIL frame1_score: got %0d want 0", score); end
    for (int k = 0; k < 8; k++) begin
      probe(hs[k], 10'd0, p);
      n_tests++; if (p !== ex[k]) begin n_fail++; $display("FAIL frame1_table h=%0d: got %b want %b", hs[k], p, ex[k]); end
    end
  endtask

  task automatic test_pass();
    logic p;
    bird_y = 10'd130;
    repeat (390) tick();
    n_tests++; if (score !== 16'd0) begin n_fail++; $display("FAIL pre_pass_score: got %0d want 0", score); end
    probe(10'd49, 10'd0, p);
    n_tests++; if (p !== 1'b1) begin n_fail++; $display("FAIL x0_at_49: got %b want 1", p); end
    tick();
    n_tests++; if (score !== 16'd1) begin n_fail++; $display("FAIL pass_score: got %0d want 1", score); end
    probe(10'd47, 10'd0, p);
    n_tests++; if (p !== 1'b0) begin n_fail++; $display("FAIL x0_at_48_left: got %b want 0", p); end
    tick();
    n_tests++; if (score !== 16'd1) begin n_fail++; $display("FAIL pass_once: got %0d want 1", score); end
    n_tests++; if (game_state !== 2'd1) begin n_fail++; $display("FAIL pass_state: got %0d want 1", game_state); end
  endtask

  task automatic test_recycle();
    logic p;
    logic [9:0] hs [10] = '{10'd634, 10'd635, 10'd686, 10'd687, 10'd126, 10'd127,
                            10'd640, 10'd640, 10'd640, 10'd640};
    logic [9:0] vs [10] = '{10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0,
                            10'd169, 10'd170, 10'd259, 10'd260};
    logic       ex [10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    repeat (46) tick();
    probe(10'd0, 10'd0, p);
    n_tests++; if (p !== 1'b0) begin n_fail++; $display("FAIL x0_at_1_h0: got %b want 0", p); end
    probe(10'd1, 10'd0, p);
    n_tests++; if (p !== 1'b1) begin n_fail++; $display("FAIL x0_at_1_h1: got %b want 1", p); end
    // x0=1 recycles to 509+127-1=635 with gap 80+0x5A=170; others step down by one.
    tick();
    for (int k = 0; k < 10; k++) begin
      probe(hs[k], vs[k], p);
      n_tests++; if (p !== ex[k]) begin n_fail++; $display("FAIL recycle1 h=%0d v=%0d: got %b want %b", hs[k], vs[k], p, ex[k]); end
    end
    n_tests++; if (score !== 16'd1) begin n_fail++; $display("FAIL recycle1_score: got %0d want 1", score); end
  endtask

  task automatic test_lfsr_step();
    logic p;
    logic [9:0] hs [8] = '{10'd634, 10'd635, 10'd640, 10'd640, 10'd640, 10'd640, 10'd640, 10'd640};
    logic [9:0] vs [8] = '{10'd0, 10'd0, 10'd259, 10'd260, 10'd349, 10'd350, 10'd439, 10'd440};
    logic       ex [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    bird_y = 10'd170;
    repeat (126) tick();
    n_tests++; if (score !== 16'd2) begin n_fail++; $display("FAIL pass2_score: got %0d want 2", score); end
    // LFSR 0x5A -> 0xB4 via {lfsr[6:0], lfsr[7]^lfsr[5]}: pipe 1 lands at 635 with gap 260.
    tick();
    for (int k = 0; k < 8; k++) begin
      probe(hs[k], vs[k], p);
      n_tests++; if (p !== ex[k]) begin n_fail++; $display("FAIL recycle2 h=%0d v=%0d: got %b want %b", hs[k], vs[k], p, ex[k]); end
    end
    n_tests++; if (game_state !== 2'd1) begin n_fail++; $display("FAIL recycle2_state: got %0d want 1", game_state); end
  endtask

  task automatic test_pipe_collision();
    logic p;
    bird_y = 10'd50;
    tick();
    n_tests++; if (game_state !== 2'd2) begin n_fail++; $display("FAIL hit_state: got %0d want 2", game_state); end
    n_tests++; if (collision !== 1'b1) begin n_fail++; $display("FAIL hit_collision: got %b want 1", collision); end
    n_tests++; if (score !== 16'd2) begin n_fail++; $display("FAIL hit_score: got %0d want 2", score); end
    @(negedge clk50) frame_tick = 1'b1;
    @(negedge clk50) frame_tick = 1'b0;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL dead_busy: got %b want 0", busy); end
    repeat (12) @(negedge clk50);
    tick();
    probe(10'd125, 10'd0, p);
    n_tests++; if (p !== 1'b0) begin n_fail++; $display("FAIL dead_frozen_125: got %b want 0", p); end
    probe(10'd126, 10'd0, p);
    n_tests++; if (p !== 1'b1) begin n_fail++; $display("FAIL dead_frozen_126: got %b want 1", p); end
    n_tests++; if (score !== 16'd2) begin n_fail++; $display("FAIL dead_score: got %0d want 2", score); end
    n_tests++; if (game_state !== 2'd2) begin n_fail++; $display("FAIL dead_state: got %0d want 2", game_state); end
  endtask

  task automatic test_restart();
    logic p;
    logic [9:0] hs [4] = '{10'd439, 10'd440, 10'd450, 10'd450};
    logic [9:0] vs [4] = '{10'd0, 10'd0, 10'd79, 10'd80};
    logic       ex [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    bird_y = 10'd130;
    pulse_start();
    n_tests++; if (game_state !== 2'd1) begin n_fail++; $display("FAIL restart_state: got %0d want 1", game_state); end
    n_tests++; if (score !== 16'd0) begin n_fail++; $display("FAIL restart_score: got %0d want 0", score); end
    n_tests++; if (collision !== 1'b0) begin n_fail++; $display("FAIL restart_collision: got %b want 0", collision); end
    for (int k = 0; k < 4; k++) begin
      probe(hs[k], vs[k], p);
      n_tests++; if (p !== ex[k]) begin n_fail++; $display("FAIL restart_table h=%0d v=%0d: got %b want %b", hs[k], vs[k], p, ex[k]); end
    end
  endtask

  task automatic test_ground();
    bird_y = 10'd416;
    tick();
    n_tests++; if (game_state !== 2'd1) begin n_fail++; $display("FAIL ground_edge_state: got %0d want 1", game_state); end
    n_tests++; if (collision !== 1'b0) begin n_fail++; $display("FAIL ground_edge_collision: got %b want 0", collision); end
    bird_y = 10'd417;
    tick();
    n_tests++; if (game_state !== 2'd2) begin n_fail++; $display("FAIL ground_hit_state: got %0d want 2", game_state); end
    n_tests++; if (collision !== 1'b1) begin n_fail++; $display("FAIL ground_hit_collision: got %b want 1", collision); end
    bird_y = 10'd130;
    pulse_start();
    n_tests++; if (game_state !== 2'd1) begin n_fail++; $display("FAIL ground_restart: got %0d want 1", game_state); end
  endtask

  task automatic test_tick_while_busy();
    logic p;
    @(negedge clk50) frame_tick = 1'b1;
    @(negedge clk50) frame_tick = 1'b0;
    repeat (2) @(negedge clk50);
    frame_tick = 1'b1;                    // lands in SCAN
    @(negedge clk50) frame_tick = 1'b0;
    repeat (7) @(negedge clk50);
    frame_tick = 1'b1;                    // lands in CHECK
    @(negedge clk50) frame_tick = 1'b0;
    @(negedge clk50);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL dropped_tick_busy_a: got %b want 0", busy); end
    @(negedge clk50);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL dropped_tick_busy_b: got %b want 0", busy); end
    probe(10'd438, 10'd0, p);
    n_tests++; if (p !== 1'b0) begin n_fail++; $display("FAIL one_step_438: got %b want 0", p); end
    probe(10'd439, 10'd0, p);
    n_tests++; if (p !== 1'b1) begin n_fail++; $display("FAIL one_step_439: got %b want 1", p); end
    // start in WAIT must not re-init the table.
    pulse_start();
    probe(10'd439, 10'd0, p);
    n_tests++; if (p !== 1'b1) begin n_fail++; $display("FAIL start_ignored: got %b want 1", p); end
    tick();
    probe(10'd437, 10'd0, p);
    n_tests++; if (p !== 1'b0) begin n_fail++; $display("FAIL second_step_437: got %b want 0", p); end
    probe(10'd438, 10'd0, p);
    n_tests++; if (p !== 1'b1) begin n_fail++; $display("FAIL second_step_438: got %b want 1", p); end
  endtask

  task automatic test_reset_mid_walk();
    logic p;
    @(negedge clk50) frame_tick = 1'b1;
    @(negedge clk50) frame_tick = 1'b0;
    repeat (7) @(negedge clk50);
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_walk_busy: got %b want 1", busy); end
    reset = 1'b1;
    #1;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_walk_busy: got %b want 0", busy); end
    n_tests++; if (game_state !== 2'd0) begin n_fail++; $display("FAIL rst_walk_state: got %0d want 0", game_state); end
    n_tests++; if (pipe_pixel !== 1'b0) begin n_fail++; $display("FAIL rst_walk_pixel: got %b want 0", pipe_pixel); end
    n_tests++; if (score !== 16'd0) begin n_fail++; $display("FAIL rst_walk_score: got %0d want 0", score); end
    @(negedge clk50) reset = 1'b0;
    repeat (15) @(negedge clk50);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_walk_no_resume: got %b want 0", busy); end
    probe(10'd439, 10'd0, p);
    n_tests++; if (p !== 1'b0) begin n_fail++; $display("FAIL rst_walk_table_439: got %b want 0", p); end
    probe(10'd440, 10'd0, p);
    n_tests++; if (p !== 1'b1) begin n_fail++; $display("FAIL rst_walk_table_440: got %b want 1", p); end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_pass();
    test_recycle();
    test_lfsr_step();
    test_pipe_collision();
    test_restart();
    test_ground();
    test_tick_while_busy();
    test_reset_mid_walk();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
